// File: rtl/sva_fail_report_arbiter_pkg.sv
// ------------------------------------------------------------------------
// sva_rpt_pkg : shared report type and arithmetic helpers.  Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package sva_rpt_pkg;

  localparam int C_N_SRC = 4;
  localparam int C_CNT_W = 8;
  localparam int C_ID_W  = (C_N_SRC > 1) ? $clog2(C_N_SRC) : 1;

  typedef struct packed {
    logic [C_ID_W-1:0]  id;
    logic [C_CNT_W-1:0] cnt;
    logic               ovf;
  } rpt_t;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
    return n;
  endfunction

  // Sum clipped to the largest value representable in 'width' bits (width <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int width);
    logic [32:0] s;
    logic [32:0] mx;
    s  = {1'b0, a} + {1'b0, b};
    mx = (33'd1 << width) - 33'd1;
    return (s > mx) ? mx[31:0] : s[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sva_fail_report_arbiter_rr.sv
// ------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, search starts after ptr.  Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] gnt_idx,
  output logic            gnt_any
);

  always_comb begin
    int idx;
    logic [ID_W-1:0] w_idx;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx   = (int'(ptr) + k) % N;
      w_idx = ID_W'(idx);
      if (!gnt_any && req[w_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sva_fail_report_arbiter.sv
// ------------------------------------------------------------------------
// sva_fail_report_arbiter : coalesces assertion fail pulses onto one report channel.  Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module sva_fail_report_arbiter
  import sva_rpt_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int CNT_W = 8,
  parameter int TOT_W = 16,
  localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] fail_pulse,
  input  logic             clr,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [ID_W-1:0]  rpt_id,
  output logic [CNT_W-1:0] rpt_cnt,
  output logic             rpt_ovf,
  output logic [TOT_W-1:0] total_fail
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [CNT_W-1:0] r_pend [N_SRC];
  logic [N_SRC-1:0] r_ovf;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [N_SRC-1:0] w_pend_nz;
  logic [ID_W-1:0]  w_gnt;
  logic             w_gnt_any;
  logic             w_load;
  logic [TOT_W-1:0] w_total_nxt;

  for (genvar i = 0; i < N_SRC; i++) begin : g_nz
    assign w_pend_nz[i] = (r_pend[i] != '0);
  end

  rr_arbiter #(.N(N_SRC), .ID_W(ID_W)) u_rr (
    .req     (w_pend_nz),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_gnt),
    .gnt_any (w_gnt_any)
  );

  // Only counts already registered can be granted; this cycle's pulses land next cycle.
  assign w_load      = (!rpt_valid || rpt_ready) && w_gnt_any;
  assign w_total_nxt = TOT_W'(sat_add(32'(total_fail), 32'(popcount(32'(fail_pulse))), TOT_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SRC; i++) r_pend[i] <= '0;
      r_ovf      <= '0;
      total_fail <= '0;
    end else if (clr) begin
      for (int i = 0; i < N_SRC; i++) r_pend[i] <= '0;
      r_ovf      <= '0;
      total_fail <= '0;
    end else begin
      total_fail <= w_total_nxt;
      for (int i = 0; i < N_SRC; i++) begin
        if (w_load && (w_gnt == ID_W'(i))) begin
          r_pend[i] <= fail_pulse[i] ? CNT_W'(1) : '0;
          r_ovf[i]  <= 1'b0;
        end else if (fail_pulse[i]) begin
          if (r_pend[i] != c_cnt_max) r_pend[i] <= r_pend[i] + CNT_W'(1);
          else                        r_ovf[i]  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr  <= ID_W'(N_SRC - 1);
      rpt_valid <= 1'b0;
      rpt_id    <= '0;
      rpt_cnt   <= '0;
      rpt_ovf   <= 1'b0;
    end else if (clr) begin
      rpt_valid <= 1'b0;
    end else if (w_load) begin
      r_rr_ptr  <= w_gnt;
      rpt_valid <= 1'b1;
      rpt_id    <= w_gnt;
      rpt_cnt   <= r_pend[w_gnt];
      rpt_ovf   <= r_ovf[w_gnt];
    end else if (rpt_valid && rpt_ready) begin
      rpt_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sva_fail_report_arbiter.sv
// ------------------------------------------------------------------------
// tb_sva_fail_report_arbiter : vector table plus report scoreboard.  Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_sva_fail_report_arbiter;
  import sva_rpt_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  fail_pulse;
  logic        clr;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [1:0]  rpt_id;
  logic [7:0]  rpt_cnt;
  logic        rpt_ovf;
  logic [15:0] total_fail;

  int checks = 0;
  int errors = 0;
  rpt_t q[$];

  sva_fail_report_arbiter #(.N_SRC(4), .CNT_W(8), .TOT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fail_pulse (fail_pulse),
    .clr        (clr),
    .rpt_valid  (rpt_valid),
    .rpt_ready  (rpt_ready),
    .rpt_id     (rpt_id),
    .rpt_cnt    (rpt_cnt),
    .rpt_ovf    (rpt_ovf),
    .total_fail (total_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_first;
    logic [3:0]  pulse;
    logic        ready;
    logic        ev;
    logic [1:0]  eid;
    logic [7:0]  ecnt;
    logic        eovf;
    logic [15:0] etot;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic care, input logic ev, input logic [1:0] eid,
                         input logic [7:0] ecnt, input logic eovf, input logic [15:0] etot);
    chk({tag, ".valid"}, 32'(rpt_valid), 32'(ev));
    chk({tag, ".total"}, 32'(total_fail), 32'(etot));
    if (care) begin
      chk({tag, ".id"},  32'(rpt_id),  32'(eid));
      chk({tag, ".cnt"}, 32'(rpt_cnt), 32'(ecnt));
      chk({tag, ".ovf"}, 32'(rpt_ovf), 32'(eovf));
    end
  endtask

  task automatic cyc(input logic [3:0] p, input logic r);
    fail_pulse = p;
    rpt_ready  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    fail_pulse = '0;
    rpt_ready  = 1'b0;
    clr        = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_out("reset", 1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 16'd0);
    rst_n = 1'b1;
  endtask

  // Scoreboard: every accepted report must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && !clr && rpt_valid && rpt_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_report: got id=%0d cnt=%0d ovf=%0d expected none", rpt_id, rpt_cnt, rpt_ovf);
      end else begin
        rpt_t e;
        e = q.pop_front();
        chk("sb.id",  32'(rpt_id),  32'(e.id));
        chk("sb.cnt", 32'(rpt_cnt), 32'(e.cnt));
        chk("sb.ovf", 32'(rpt_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    rst_n      = 1'b1;
    fail_pulse = '0;
    clr        = 1'b0;
    rpt_ready  = 1'b0;

    // single pulse on src2, then all four sources together from a fresh reset
    tbl[0] = '{1'b1, 4'b0100, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 16'd1};
    tbl[1] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 8'd1, 1'b0, 16'd1};
    tbl[2] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 16'd1};
    tbl[3] = '{1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 16'd4};
    tbl[4] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 8'd1, 1'b0, 16'd4};
    tbl[5] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 8'd1, 1'b0, 16'd4};
    tbl[6] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 8'd1, 1'b0, 16'd4};
    tbl[7] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 8'd1, 1'b0, 16'd4};
    tbl[8] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 16'd4};

    for (int k = 0; k < 9; k++) begin
      if (tbl[k].rst_first) do_reset();
      cyc(tbl[k].pulse, tbl[k].ready);
      if (tbl[k].ev && tbl[k].ready) q.push_back('{id: tbl[k].eid, cnt: tbl[k].ecnt, ovf: tbl[k].eovf});
      chk_out($sformatf("vec%0d", k), tbl[k].ev, tbl[k].ev, tbl[k].eid, tbl[k].ecnt, tbl[k].eovf, tbl[k].etot);
    end

    // back-pressure coalescing on src1
    q.push_back('{id: 2'd1, cnt: 8'd1, ovf: 1'b0});
    q.push_back('{id: 2'd1, cnt: 8'd4, ovf: 1'b0});
    cyc(4'b0010, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(4'b0010, 1'b0);
      chk_out($sformatf("bp_hold%0d", k), 1'b1, 1'b1, 2'd1, 8'd1, 1'b0, 16'(6 + k));
    end
    cyc(4'b0000, 1'b0);
    chk_out("bp_idle", 1'b1, 1'b1, 2'd1, 8'd1, 1'b0, 16'd9);
    cyc(4'b0000, 1'b1);
    chk_out("bp_release", 1'b1, 1'b1, 2'd1, 8'd4, 1'b0, 16'd9);
    cyc(4'b0000, 1'b1);
    chk_out("bp_drain", 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 16'd9);

    // counter saturation on src3
    q.push_back('{id: 2'd3, cnt: 8'd1,   ovf: 1'b0});
    q.push_back('{id: 2'd3, cnt: 8'd255, ovf: 1'b1});
    q.push_back('{id: 2'd3, cnt: 8'd1,   ovf: 1'b0});
    repeat (300) cyc(4'b1000, 1'b0);
    chk_out("sat_hold", 1'b1, 1'b1, 2'd3, 8'd1, 1'b0, 16'd309);
    cyc(4'b0000, 1'b1);
    chk_out("sat_report", 1'b1, 1'b1, 2'd3, 8'd255, 1'b1, 16'd309);
    cyc(4'b0000, 1'b1);
    chk_out("sat_drain", 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 16'd309);
    cyc(4'b1000, 1'b1);
    cyc(4'b0000, 1'b1);
    chk_out("sat_after", 1'b1, 1'b1, 2'd3, 8'd1, 1'b0, 16'd310);
    cyc(4'b0000, 1'b1);
    chk_out("sat_idle", 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 16'd310);

    // pulse arriving on the same edge its count is loaded
    q.push_back('{id: 2'd0, cnt: 8'd1, ovf: 1'b0});
    q.push_back('{id: 2'd0, cnt: 8'd1, ovf: 1'b0});
    cyc(4'b0001, 1'b1);
    chk_out("lwp_pend", 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 16'd311);
    cyc(4'b0001, 1'b1);
    chk_out("lwp_first", 1'b1, 1'b1, 2'd0, 8'd1, 1'b0, 16'd312);
    cyc(4'b0000, 1'b1);
    chk_out("lwp_second", 1'b1, 1'b1, 2'd0, 8'd1, 1'b0, 16'd312);
    cyc(4'b0000, 1'b1);
    chk_out("lwp_idle", 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 16'd312);

    // global tally saturation, then clr with a report pending
    repeat (16400) cyc(4'b1111, 1'b0);
    chk_out("tot_sat", 1'b1, 1'b1, 2'd1, 8'd1, 1'b0, 16'hFFFF);
    clr = 1'b1;
    cyc(4'b1111, 1'b0);
    clr = 1'b0;
    chk_out("clr", 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 16'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(4'b0000, 1'b1);
      chk_out($sformatf("clr_nostale%0d", k), 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 16'd0);
    end

    // asynchronous reset mid-stream
    cyc(4'b0100, 1'b0);
    cyc(4'b0100, 1'b0);
    chk_out("arst_pre", 1'b1, 1'b1, 2'd2, 8'd1, 1'b0, 16'd2);
    fail_pulse = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("arst_now", 1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'b0000, 1'b1);
    chk_out("arst_after", 1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 16'd0);

    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
